// File: rtl/count_mon_pkg.sv
// ---------------------------------------------------------------------------
// count_mon_pkg
// Shared types and constants for the counter sequence monitor.
//   state_t  : monitor tracking state (2-bit encoding)
//   DIR_UP   : dir value while the counter is counting up
//   DIR_DOWN : dir value while the counter is counting down
//   is_locked: true for the two locked states
// ---------------------------------------------------------------------------
package count_mon_pkg;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    SYNC      = 2'd1,
    LOCK_UP   = 2'd2,
    LOCK_DOWN = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic logic is_locked(input state_t s);
    return (s == LOCK_UP) || (s == LOCK_DOWN);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event tally that counts up on inc and holds at all-ones instead of
// rolling over.
// Ports:
//   clk   in   rising-edge clock
//   clear in   synchronous clear, has priority over inc
//   inc   in   add one this cycle (ignored once saturated)
//   count out  registered tally, WIDTH bits
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_seq_monitor.sv
// ---------------------------------------------------------------------------
// count_seq_monitor
// Passive observer of an up/down counter's Q bus. Learns the count
// direction, locks onto the sequence, flags illegal jumps and wrap-arounds,
// and keeps saturating tallies of both. Drives nothing back to the counter.
//
// Build option: define STRICT_DIR_EN to make a direction reversal while
// locked illegal (err pulse, drop back to SYNC). Without it reversals are
// followed silently.
//
// Ports:
//   clk        in   rising-edge clock shared with the counter
//   reset_n    in   synchronous active-low reset
//   sample_en  in   counter clocked this cycle; sample q
//   q          in   counter Q bus, WIDTH bits, bit 0 = LSB
//   load_seen  in   counter was loaded; resynchronise on q (beats sample_en)
//   locked     out  tracking a direction (LOCK_UP or LOCK_DOWN)
//   dir        out  0 = up, 1 = down; meaningful while locked
//   err        out  one-cycle pulse on an illegal transition
//   wrap       out  one-cycle pulse on a wrap-around in the locked direction
//   err_count  out  saturating count of err pulses, CNT_W bits
//   wrap_count out  saturating count of wrap pulses, CNT_W bits
// ---------------------------------------------------------------------------
module count_seq_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] q,
  input  logic             load_seen,
  output logic             locked,
  output logic             dir,
  output logic             err,
  output logic             wrap,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic             locked_q, locked_d;

  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;
  logic             is_stall;
  logic             is_inc;
  logic             is_dec;

  assign inc_val  = ref_q + WIDTH'(1);
  assign dec_val  = ref_q - WIDTH'(1);
  assign is_stall = (q == ref_q);
  assign is_inc   = (q == inc_val);
  assign is_dec   = (q == dec_val);

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    dir_d   = dir_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;

    if (load_seen) begin
      // A load makes the old reference meaningless; start over from q.
      ref_d   = q;
      state_d = SYNC;
    end else if (sample_en) begin
      ref_d = q;
      unique case (state_q)
        UNLOCKED: begin
          state_d = SYNC;
        end

        SYNC: begin
          if (is_stall) begin
            state_d = SYNC;
          end else if (is_inc && (!is_dec || dir_q == DIR_UP)) begin
            // When inc == dec (1-bit counter) keep the last known direction.
            dir_d   = DIR_UP;
            state_d = LOCK_UP;
          end else if (is_dec) begin
            dir_d   = DIR_DOWN;
            state_d = LOCK_DOWN;
          end else begin
            state_d = SYNC;
          end
        end

        LOCK_UP: begin
          // inc is tested before dec so a 1-bit counter continues upward.
          if (is_stall) begin
            state_d = LOCK_UP;
          end else if (is_inc) begin
            wrap_d = (ref_q == {WIDTH{1'b1}});
          end else if (is_dec) begin
`ifdef STRICT_DIR_EN
            err_d   = 1'b1;
            state_d = SYNC;
`else
            dir_d   = DIR_DOWN;
            state_d = LOCK_DOWN;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = SYNC;
          end
        end

        LOCK_DOWN: begin
          if (is_stall) begin
            state_d = LOCK_DOWN;
          end else if (is_dec) begin
            wrap_d = (ref_q == {WIDTH{1'b0}});
          end else if (is_inc) begin
`ifdef STRICT_DIR_EN
            err_d   = 1'b1;
            state_d = SYNC;
`else
            dir_d   = DIR_UP;
            state_d = LOCK_UP;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = SYNC;
          end
        end

        default: begin
          state_d = UNLOCKED;
        end
      endcase
    end

    // locked is registered from the next state so it lines up with dir.
    locked_d = is_locked(state_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= UNLOCKED;
      ref_q    <= '0;
      dir_q    <= DIR_UP;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
      locked_q <= locked_d;
    end
  end

  // Tallies advance on the same edge that registers their pulse.
  sat_counter #(
    .WIDTH (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .clear (~reset_n),
    .inc   (err_d),
    .count (err_count)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_wrap_cnt (
    .clk   (clk),
    .clear (~reset_n),
    .inc   (wrap_d),
    .count (wrap_count)
  );

  assign locked = locked_q;
  assign dir    = dir_q;
  assign err    = err_q;
  assign wrap   = wrap_q;

endmodule
